// File: rtl/edge_relax_engine.sv
// edge_relax_engine: single-source relaxation over one adjacency list.
// Streams packed adjacency lines from graph memory, reads each daughter's
// {dist, pred} from working memory and writes {src_dist+w, src_node} back
// when the candidate is strictly shorter. Every output is a flop; the
// next-state logic precomputes what each output must be in the next state.
module edge_relax_engine #(
  parameter int NODE_W         = 8,
  parameter int WEIGHT_W       = 8,
  parameter int DIST_W         = 64,
  parameter int EDGES_PER_LINE = 8,
  parameter int ADDR_W         = 13,
  parameter int CNT_W          = 8
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [NODE_W-1:0]                            src_node,
  input  logic [DIST_W-1:0]                            src_dist,
  input  logic [ADDR_W-1:0]                            adj_base,
  input  logic [CNT_W-1:0]                             edge_count,
  output logic                                         busy,
  output logic                                         done,
  output logic [CNT_W-1:0]                             relaxed_count,
  output logic                                         gm_rd,
  output logic [ADDR_W-1:0]                            gm_addr,
  input  logic [EDGES_PER_LINE*(NODE_W+WEIGHT_W)-1:0] gm_rdata,
  output logic                                         wm_rd,
  output logic                                         wm_wr,
  output logic [NODE_W-1:0]                            wm_addr,
  input  logic [DIST_W+NODE_W-1:0]                     wm_rdata,
  output logic [DIST_W+NODE_W-1:0]                     wm_wdata
);

  localparam int EW     = NODE_W + WEIGHT_W;
  localparam int LINE_W = EDGES_PER_LINE * EW;
  localparam int SLOT_W = (EDGES_PER_LINE > 1) ? $clog2(EDGES_PER_LINE) : 1;
  localparam int WM_W   = DIST_W + NODE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_GM_REQ, S_GM_WAIT, S_RD, S_EVAL, S_WR, S_DONE
  } state_t;

  // Slot 0 sits in the MSBs; inside a slot the daughter id is above the weight.
  function automatic logic [NODE_W-1:0] slot_node(input logic [LINE_W-1:0] ln,
                                                  input logic [SLOT_W-1:0] k);
    return NODE_W'(ln >> ((EDGES_PER_LINE - 1 - int'(k)) * EW + WEIGHT_W));
  endfunction

  function automatic logic [WEIGHT_W-1:0] slot_weight(input logic [LINE_W-1:0] ln,
                                                      input logic [SLOT_W-1:0] k);
    return WEIGHT_W'(ln >> ((EDGES_PER_LINE - 1 - int'(k)) * EW));
  endfunction

  state_t              state_q, state_d;
  logic [NODE_W-1:0]   src_node_q, src_node_d;
  logic [DIST_W-1:0]   src_dist_q, src_dist_d;
  logic [CNT_W-1:0]    edge_count_q, edge_count_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [LINE_W-1:0]   line_buf_q, line_buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    relaxed_count_q, relaxed_count_d;
  logic                gm_rd_q, gm_rd_d;
  logic [ADDR_W-1:0]   gm_addr_q, gm_addr_d;
  logic                wm_rd_q, wm_rd_d;
  logic                wm_wr_q, wm_wr_d;
  logic [NODE_W-1:0]   wm_addr_q, wm_addr_d;
  logic [WM_W-1:0]     wm_wdata_q, wm_wdata_d;

  logic [WEIGHT_W-1:0] cur_weight;
  logic [DIST_W:0]     sum;
  logic [DIST_W-1:0]   cand;
  logic                relax;
  logic                last_edge;
  logic                last_slot;
  logic                advance;
  logic                unused_pred;

  // Candidate distance for the slot under evaluation; wm_addr_q still holds
  // its daughter id, so the self-loop test compares against that.
  assign cur_weight  = slot_weight(line_buf_q, slot_q);
  assign sum         = {1'b0, src_dist_q} + {{(DIST_W + 1 - WEIGHT_W){1'b0}}, cur_weight};
  assign cand        = sum[DIST_W] ? {DIST_W{1'b1}} : sum[DIST_W-1:0];
  assign relax       = (cand < wm_rdata[WM_W-1 -: DIST_W]) &&
                       (wm_addr_q != src_node_q) &&
                       (src_dist_q != {DIST_W{1'b1}});
  assign last_edge   = ({1'b0, idx_q} + (CNT_W + 1)'(1)) == {1'b0, edge_count_q};
  assign last_slot   = (slot_q == SLOT_W'(EDGES_PER_LINE - 1));
  assign unused_pred = ^wm_rdata[NODE_W-1:0];

  // Next state plus the registered value every output takes in that state.
  always_comb begin
    state_d         = state_q;
    src_node_d      = src_node_q;
    src_dist_d      = src_dist_q;
    edge_count_d    = edge_count_q;
    idx_d           = idx_q;
    slot_d          = slot_q;
    line_buf_d      = line_buf_q;
    done_d          = 1'b0;
    relaxed_count_d = relaxed_count_q;
    gm_rd_d         = 1'b0;
    gm_addr_d       = gm_addr_q;
    wm_rd_d         = 1'b0;
    wm_wr_d         = 1'b0;
    wm_addr_d       = wm_addr_q;
    wm_wdata_d      = wm_wdata_q;
    advance         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_node_d      = src_node;
          src_dist_d      = src_dist;
          edge_count_d    = edge_count;
          relaxed_count_d = '0;
          idx_d           = '0;
          slot_d          = '0;
          if (edge_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_GM_REQ;
            gm_rd_d   = 1'b1;
            gm_addr_d = adj_base;
          end
        end
      end
      S_GM_REQ: state_d = S_GM_WAIT;
      S_GM_WAIT: begin
        // The line is not in the buffer yet, so take the first daughter
        // straight from the memory data.
        line_buf_d = gm_rdata;
        state_d    = S_RD;
        wm_rd_d    = 1'b1;
        wm_addr_d  = slot_node(gm_rdata, slot_q);
      end
      S_RD: state_d = S_EVAL;
      S_EVAL: begin
        if (relax) begin
          state_d         = S_WR;
          wm_wr_d         = 1'b1;
          wm_wdata_d      = {cand, src_node_q};
          relaxed_count_d = relaxed_count_q + CNT_W'(1);
        end else begin
          advance = 1'b1;
        end
      end
      S_WR:    advance = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (last_edge) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else if (last_slot) begin
        state_d   = S_GM_REQ;
        gm_rd_d   = 1'b1;
        gm_addr_d = gm_addr_q + ADDR_W'(1);
        idx_d     = idx_q + CNT_W'(1);
        slot_d    = '0;
      end else begin
        state_d   = S_RD;
        wm_rd_d   = 1'b1;
        wm_addr_d = slot_node(line_buf_q, slot_q + SLOT_W'(1));
        idx_d     = idx_q + CNT_W'(1);
        slot_d    = slot_q + SLOT_W'(1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation on the spot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      src_node_q      <= '0;
      src_dist_q      <= '0;
      edge_count_q    <= '0;
      idx_q           <= '0;
      slot_q          <= '0;
      line_buf_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      relaxed_count_q <= '0;
      gm_rd_q         <= 1'b0;
      gm_addr_q       <= '0;
      wm_rd_q         <= 1'b0;
      wm_wr_q         <= 1'b0;
      wm_addr_q       <= '0;
      wm_wdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      src_node_q      <= src_node_d;
      src_dist_q      <= src_dist_d;
      edge_count_q    <= edge_count_d;
      idx_q           <= idx_d;
      slot_q          <= slot_d;
      line_buf_q      <= line_buf_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      relaxed_count_q <= relaxed_count_d;
      gm_rd_q         <= gm_rd_d;
      gm_addr_q       <= gm_addr_d;
      wm_rd_q         <= wm_rd_d;
      wm_wr_q         <= wm_wr_d;
      wm_addr_q       <= wm_addr_d;
      wm_wdata_q      <= wm_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign relaxed_count = relaxed_count_q;
  assign gm_rd         = gm_rd_q;
  assign gm_addr       = gm_addr_q;
  assign wm_rd         = wm_rd_q;
  assign wm_wr         = wm_wr_q;
  assign wm_addr       = wm_addr_q;
  assign wm_wdata      = wm_wdata_q;

endmodule

// File: tb/tb_edge_relax_engine.sv
// Bench for edge_relax_engine: graph/working memories, a per-operation
// reference model, and a cycle-by-cycle strobe checker.
module tb_edge_relax_engine;
  localparam int NW = 8, WW = 8, DW = 64, EPL = 8, AW = 13, CW = 8;
  localparam int EW = NW + WW, LW = EPL * EW, WMW = DW + NW;
  localparam logic [DW-1:0] INF = '1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [NW-1:0]   src_node = '0;
  logic [DW-1:0]   src_dist = '0;
  logic [AW-1:0]   adj_base = '0;
  logic [CW-1:0]   edge_count = '0;
  logic            busy, done, gm_rd, wm_rd, wm_wr;
  logic [CW-1:0]   relaxed_count;
  logic [AW-1:0]   gm_addr;
  logic [LW-1:0]   gm_rdata;
  logic [NW-1:0]   wm_addr;
  logic [WMW-1:0]  wm_rdata;
  logic [WMW-1:0]  wm_wdata;

  always #5 clock = ~clock;

  edge_relax_engine #(.NODE_W(NW), .WEIGHT_W(WW), .DIST_W(DW), .EDGES_PER_LINE(EPL),
                      .ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .src_node(src_node), .src_dist(src_dist),
    .adj_base(adj_base), .edge_count(edge_count), .busy(busy), .done(done),
    .relaxed_count(relaxed_count), .gm_rd(gm_rd), .gm_addr(gm_addr), .gm_rdata(gm_rdata),
    .wm_rd(wm_rd), .wm_wr(wm_wr), .wm_addr(wm_addr), .wm_rdata(wm_rdata), .wm_wdata(wm_wdata));

  // Memories: one-cycle read latency; working memory is also loadable by the bench.
  logic [LW-1:0]  gm_mem   [0:8191];
  logic [WMW-1:0] wm_mem   [0:255];
  logic [WMW-1:0] model_wm [0:255];
  logic           ld_en = 1'b0;
  logic [NW-1:0]  ld_addr = '0;
  logic [WMW-1:0] ld_data = '0;

  always @(posedge clock) begin
    if (gm_rd) gm_rdata <= gm_mem[gm_addr];
    if (wm_rd) wm_rdata <= wm_mem[wm_addr];
    if (wm_wr) wm_mem[wm_addr] <= wm_wdata;
    else if (ld_en) wm_mem[ld_addr] <= ld_data;
  end

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_gm [$];
  logic [NW-1:0] exp_rd [$];
  logic [79:0]   exp_wr [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got strobe want none", name);
  endtask

  // Every strobe must be exclusive and match the next expected memory access.
  logic [79:0] cur_wr;
  int          nstrobe;
  always @(negedge clock) begin
    if (!reset) begin
      nstrobe = int'(gm_rd) + int'(wm_rd) + int'(wm_wr);
      if (nstrobe != 0) chk("strobe_excl", 128'(nstrobe), 128'(1));
      if (gm_rd) begin
        if (exp_gm.size() == 0) unexpected("gm_rd");
        else chk("gm_addr", 128'(gm_addr), 128'(exp_gm.pop_front()));
      end
      if (wm_rd) begin
        if (exp_rd.size() == 0) unexpected("wm_rd");
        else chk("wm_rd_addr", 128'(wm_addr), 128'(exp_rd.pop_front()));
      end
      if (wm_wr) begin
        if (exp_wr.size() == 0) unexpected("wm_wr");
        else begin
          cur_wr = exp_wr.pop_front();
          chk("wm_wr_addr", 128'(wm_addr), 128'(cur_wr[79:72]));
          chk("wm_wdata", 128'(wm_wdata), 128'(cur_wr[71:0]));
        end
      end
    end
  end

  // Reference: walk the edge list, queue expected accesses, update model memory.
  task automatic model_op(input logic [NW-1:0] sn, input logic [DW-1:0] sd,
                          input logic [AW-1:0] base, input logic [CW-1:0] e,
                          output int t, output int r);
    int l;
    logic [LW-1:0] ln;
    logic [EW-1:0] f;
    logic [NW-1:0] d;
    logic [WW-1:0] w;
    logic [DW:0]   s;
    logic [DW-1:0] c;
    l = (int'(e) + EPL - 1) / EPL;
    r = 0;
    for (int i = 0; i < l; i++) exp_gm.push_back(AW'(int'(base) + i));
    for (int i = 0; i < int'(e); i++) begin
      ln = gm_mem[AW'(int'(base) + i / EPL)];
      f  = EW'(ln >> ((EPL - 1 - (i % EPL)) * EW));
      d  = f[EW-1 -: NW];
      w  = f[WW-1:0];
      exp_rd.push_back(d);
      s = {1'b0, sd} + (DW + 1)'(w);
      c = s[DW] ? INF : s[DW-1:0];
      if (c < model_wm[d][WMW-1 -: DW] && d != sn && sd != INF) begin
        exp_wr.push_back({d, c, sn});
        model_wm[d] = {c, sn};
        r++;
      end
    end
    t = 2 * l + 2 * int'(e) + r + 1;
  endtask

  task automatic wm_set(input logic [NW-1:0] a, input logic [WMW-1:0] v);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    model_wm[a] = v;
    @(posedge clock);
    #1 ld_en = 1'b0;
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [EW-1:0] s0, input logic [EW-1:0] rest);
    logic [LW-1:0] ln;
    ln = '0;
    for (int k = 0; k < EPL; k++) ln |= LW'(k == 0 ? s0 : rest) << ((EPL - 1 - k) * EW);
    return ln;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] ln;
    logic [EW-1:0] f;
    ln = '0;
    for (int k = 0; k < EPL; k++) begin
      f  = {NW'($urandom_range(0, 31)), WW'($urandom)};
      ln |= LW'(f) << ((EPL - 1 - k) * EW);
    end
    return ln;
  endfunction

  // One operation: model, start, then check busy/done/relaxed_count every cycle.
  task automatic run_op(input string tag, input logic [NW-1:0] sn, input logic [DW-1:0] sd,
                        input logic [AW-1:0] base, input logic [CW-1:0] e, input bit hold,
                        output int t, output int r);
    model_op(sn, sd, base, e, t, r);
    @(negedge clock);
    start = 1'b1; src_node = sn; src_dist = sd; adj_base = base; edge_count = e;
    @(posedge clock);
    if (!hold) #1 start = 1'b0;
    for (int c = 1; c <= t + 3; c++) begin
      @(negedge clock);
      chk({tag, "_busy"}, 128'(busy), 128'(c <= t));
      chk({tag, "_done"}, 128'(done), 128'(c == t));
      if (c == t) begin
        chk({tag, "_relaxed_count"}, 128'(relaxed_count), 128'(r));
        start = 1'b0;
      end
    end
    chk({tag, "_gm_left"}, 128'(exp_gm.size()), 128'(0));
    chk({tag, "_rd_left"}, 128'(exp_rd.size()), 128'(0));
    chk({tag, "_wr_left"}, 128'(exp_wr.size()), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r;
    bit seen;
    for (int a = 0; a < 256; a++) gm_mem[a] = rnd_line();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_gm_rd", 128'(gm_rd), 128'(0));
    chk("rst_wm_rd", 128'(wm_rd), 128'(0));
    chk("rst_wm_wr", 128'(wm_wr), 128'(0));
    chk("rst_relaxed", 128'(relaxed_count), 128'(0));
    chk("rst_gm_addr", 128'(gm_addr), 128'(0));
    chk("rst_wm_addr", 128'(wm_addr), 128'(0));
    chk("rst_wm_wdata", 128'(wm_wdata), 128'(0));
    reset = 1'b0;
    for (int a = 0; a < 32; a++) wm_set(NW'(a), {INF, 8'h00});

    // Single edge relax
    gm_mem[10] = mk_line({8'd3, 8'd4}, {8'd5, 8'd1});
    run_op("single", 8'd1, 64'd5, 13'd10, 8'd1, 1'b0, t, r);
    chk("single_lat_model", 128'(t), 128'(6));
    chk("single_r_model", 128'(r), 128'(1));
    chk("single_wm3", 128'(wm_mem[3]), {56'd0, 64'd9, 8'd1});

    // Candidate equal to current distance: no write
    wm_set(8'd3, {64'd9, 8'd0});
    run_op("tie", 8'd1, 64'd5, 13'd10, 8'd1, 1'b0, t, r);
    chk("tie_lat_model", 128'(t), 128'(5));
    chk("tie_r_model", 128'(r), 128'(0));

    // Two lines, partial second line
    gm_mem[20] = rnd_line();
    gm_mem[21] = rnd_line();
    run_op("multi", 8'd7, 64'd3, 13'd20, 8'd10, 1'b0, t, r);

    // Empty list
    run_op("empty", 8'd1, 64'd5, 13'd30, 8'd0, 1'b0, t, r);
    chk("empty_lat_model", 128'(t), 128'(1));

    // Self-loop is skipped
    wm_set(8'd2, {INF, 8'h00});
    gm_mem[40] = mk_line({8'd2, 8'd1}, {8'd6, 8'd1});
    run_op("selfloop", 8'd2, 64'd0, 13'd40, 8'd1, 1'b0, t, r);
    chk("selfloop_r_model", 128'(r), 128'(0));

    // Unvisited source never relaxes
    for (int a = 0; a < 32; a++) wm_set(NW'(a), {INF, 8'h00});
    run_op("src_inf", 8'd9, INF, 13'd50, 8'd8, 1'b0, t, r);
    chk("src_inf_r_model", 128'(r), 128'(0));

    // Saturating candidate against an infinite distance
    gm_mem[60] = mk_line({8'd4, 8'h20}, {8'd4, 8'h20});
    run_op("sat", 8'd1, 64'hFFFF_FFFF_FFFF_FFF0, 13'd60, 8'd1, 1'b0, t, r);
    chk("sat_r_model", 128'(r), 128'(0));

    // Start held across DONE: ignored there, re-accepted in the next IDLE
    @(negedge clock);
    start = 1'b1; edge_count = '0;
    @(posedge clock);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      chk("hold0_busy", 128'(busy), 128'(c == 1 || c == 3));
      chk("hold0_done", 128'(done), 128'(c == 1 || c == 3));
      if (c == 3) start = 1'b0;
    end

    // Start held for a whole operation: one operation only
    wm_set(8'd3, {INF, 8'h00});
    run_op("hold", 8'd1, 64'd5, 13'd10, 8'd1, 1'b1, t, r);

    // Reset during WR
    wm_set(8'd3, {INF, 8'h00});
    model_op(8'd1, 64'd5, 13'd10, 8'd1, t, r);
    @(negedge clock);
    start = 1'b1; src_node = 8'd1; src_dist = 64'd5; adj_base = 13'd10; edge_count = 8'd1;
    @(posedge clock);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (wm_wr) seen = 1'b1;
    end
    chk("rstwr_seen", 128'(seen), 128'(1));
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rstwr_wm_wr", 128'(wm_wr), 128'(0));
    chk("rstwr_busy", 128'(busy), 128'(0));
    chk("rstwr_done", 128'(done), 128'(0));
    chk("rstwr_wm_rd", 128'(wm_rd), 128'(0));
    chk("rstwr_gm_rd", 128'(gm_rd), 128'(0));
    @(negedge clock);
    reset = 1'b0;
    exp_gm.delete(); exp_rd.delete(); exp_wr.delete();

    // Randomized operations over a shared working memory
    for (int a = 0; a < 32; a++)
      wm_set(NW'(a), {($urandom_range(0, 3) == 0) ? INF : DW'($urandom_range(0, 2000)), 8'h00});
    for (int n = 0; n < 40; n++) begin
      run_op("rand",
             NW'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0) ? INF : DW'($urandom_range(0, 500)),
             AW'($urandom_range(0, 200)),
             CW'($urandom_range(0, 40)),
             ($urandom_range(0, 3) == 0), t, r);
    end
    for (int a = 0; a < 32; a++) chk("final_wm", 128'(wm_mem[a]), 128'(model_wm[a]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
